// File: rtl/bin_histogram_preprocessor_pkg.sv
// Shared types and constants for the SNN input pre-processing stage.
package snn_pre_pkg;

  localparam int unsigned NUM_BINS = 1024;
  localparam int unsigned BIN_W    = 10;
  localparam int unsigned ACT_W    = 8;
  localparam int unsigned ACT_MAX  = (1 << ACT_W) - 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    FLUSH,
    DRAIN,
    DONE
  } pre_state_t;

endpackage

// File: rtl/bin_histogram_preprocessor_if.sv
// Detector event stream and activation-memory write port bundles.
interface evt_stream_if;
  import snn_pre_pkg::*;

  logic             evt_valid;
  logic [BIN_W-1:0] evt_bin;
  logic             evt_ready;

  modport master (output evt_valid, output evt_bin, input evt_ready);
  modport slave  (input evt_valid, input evt_bin, output evt_ready);
endinterface

interface act_wr_if;
  import snn_pre_pkg::*;

  logic [BIN_W-1:0] addr_in;
  logic             act_wr_en;
  logic [ACT_W-1:0] data_in;

  modport master (output addr_in, output act_wr_en, output data_in);
  modport slave  (input addr_in, input act_wr_en, input data_in);
endinterface

// File: rtl/bin_histogram_preprocessor_hist_ram.sv
// Histogram count storage: simple dual-port RAM, synchronous read,
// read-during-write to the same address returns the old contents.
module hist_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; sees the array before this edge's write.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bin_histogram_preprocessor.sv
// Builds a per-bin event histogram over a window, then streams each bin as a
// saturated activation into the activation memory and pulses done.
module bin_histogram_preprocessor
  import snn_pre_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned SHIFT = 0,
  parameter int unsigned WIN_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  evt_stream_if.slave      evt,
  act_wr_if.master         act,
  output logic             pre_processing_done,
  output logic             busy,
  output logic [15:0]      drop_count
);

  pre_state_t       state_q;
  logic [WIN_W-1:0] win_cnt_q;
  logic [BIN_W:0]   idx_q;
  logic             flush_q;
  logic             evt_ready_q;
  logic             busy_q;
  logic             done_q;
  logic [15:0]      drop_q;

  logic             s1_vld_q;
  logic [BIN_W-1:0] s1_bin_q;
  logic             wb_vld_q;
  logic [BIN_W-1:0] wb_bin_q;
  logic [CNT_W-1:0] wb_cnt_q;
  logic             d1_vld_q;
  logic [BIN_W-1:0] d1_addr_q;
  logic             act_wr_en_q;
  logic [BIN_W-1:0] act_addr_q;
  logic [ACT_W-1:0] act_data_q;

  logic             accept;
  logic             drain_rd;
  logic [CNT_W-1:0] cur_cnt;
  logic [CNT_W-1:0] inc_cnt;
  logic             ram_wr_en;
  logic [BIN_W-1:0] ram_wr_addr;
  logic [CNT_W-1:0] ram_wr_data;
  logic             ram_rd_en;
  logic [BIN_W-1:0] ram_rd_addr;
  logic [CNT_W-1:0] ram_rd_data;

  function automatic logic [ACT_W-1:0] to_act(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] s;
    s = c >> SHIFT;
    if (s > CNT_W'(ACT_MAX)) return '1;
    return s[ACT_W-1:0];
  endfunction

  assign evt.evt_ready       = evt_ready_q;
  assign act.act_wr_en       = act_wr_en_q;
  assign act.addr_in         = act_addr_q;
  assign act.data_in         = act_data_q;
  assign pre_processing_done = done_q;
  assign busy                = busy_q;
  assign drop_count          = drop_q;

  // RAM port steering, read-modify-write forwarding and saturating increment.
  always_comb begin
    accept   = evt.evt_valid & evt_ready_q;
    drain_rd = (state_q == DRAIN) && !idx_q[BIN_W];
    cur_cnt  = (wb_vld_q && (wb_bin_q == s1_bin_q)) ? wb_cnt_q : ram_rd_data;
    inc_cnt  = (&cur_cnt) ? cur_cnt : cur_cnt + CNT_W'(1);
    if (state_q == CLEAR) begin
      ram_wr_en   = 1'b1;
      ram_wr_addr = idx_q[BIN_W-1:0];
      ram_wr_data = '0;
    end else begin
      ram_wr_en   = s1_vld_q;
      ram_wr_addr = s1_bin_q;
      ram_wr_data = inc_cnt;
    end
    ram_rd_en   = accept | drain_rd;
    ram_rd_addr = drain_rd ? idx_q[BIN_W-1:0] : evt.evt_bin;
  end

  hist_ram #(
    .DEPTH (NUM_BINS),
    .AW    (BIN_W),
    .DW    (CNT_W)
  ) u_hist_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_wr_addr),
    .wr_data (ram_wr_data),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  // Frame sequencing with registered handshake/status outputs and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      win_cnt_q   <= '0;
      idx_q       <= '0;
      flush_q     <= 1'b0;
      evt_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if ((state_q == IDLE) && start) begin
        drop_q <= '0;
      end else if (evt.evt_valid && !evt_ready_q && (drop_q != '1)) begin
        drop_q <= drop_q + 16'd1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            win_cnt_q <= (window_len == '0) ? WIN_W'(1) : window_len;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= CLEAR;
          end
        end
        CLEAR: begin
          if (idx_q == (BIN_W+1)'(NUM_BINS - 1)) begin
            idx_q       <= '0;
            evt_ready_q <= 1'b1;
            state_q     <= ACCUM;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ACCUM: begin
          if (win_cnt_q <= WIN_W'(1)) begin
            evt_ready_q <= 1'b0;
            flush_q     <= 1'b0;
            state_q     <= FLUSH;
          end else begin
            win_cnt_q <= win_cnt_q - WIN_W'(1);
          end
        end
        FLUSH: begin
          if (flush_q) state_q <= DRAIN;
          else         flush_q <= 1'b1;
        end
        DRAIN: begin
          if (!idx_q[BIN_W]) idx_q <= idx_q + 1'b1;
          if (act_wr_en_q && (act_addr_q == BIN_W'(NUM_BINS - 1))) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Accumulate pipeline (read, increment/write-back) and 2-cycle drain pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_bin_q    <= '0;
      wb_vld_q    <= 1'b0;
      wb_bin_q    <= '0;
      wb_cnt_q    <= '0;
      d1_vld_q    <= 1'b0;
      d1_addr_q   <= '0;
      act_wr_en_q <= 1'b0;
      act_addr_q  <= '0;
      act_data_q  <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) s1_bin_q <= evt.evt_bin;
      wb_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        wb_bin_q <= s1_bin_q;
        wb_cnt_q <= inc_cnt;
      end
      d1_vld_q <= drain_rd;
      if (drain_rd) d1_addr_q <= idx_q[BIN_W-1:0];
      act_wr_en_q <= d1_vld_q;
      if (d1_vld_q) begin
        act_addr_q <= d1_addr_q;
        act_data_q <= to_act(ram_rd_data);
      end
    end
  end

endmodule
